// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch queue: autonomously walks the instruction-memory
// address, captures returning words with their PC into a small FIFO, and
// presents the head entry to the CPU over a valid/ready handshake.
// Branch/jump redirects flush the queue and restart fetch at the target.
module instr_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       CLK,
  input  logic                       Reset,
  output logic [31:0]                instr_addr,
  input  logic [31:0]                instruction,
  output logic [31:0]                instr_out,
  output logic [31:0]                instr_pc,
  output logic                       instr_valid,
  input  logic                       cpu_ready,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [31:0]   fifo_pc    [DEPTH];
  logic [31:0]   fifo_instr [DEPTH];

  logic [CW:0]   pending;
  logic          issue;
  logic          capture;
  logic          pop;

  // Word-align a fetch target; the low two address bits carry no meaning.
  function automatic logic [31:0] pc_align(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

  // Sequential fetch step; wraps modulo 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Reserve a FIFO slot for every outstanding read so the queue cannot
  // overflow; a pop in the same cycle is deliberately not credited.
  assign pending = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue   = !redirect_valid && (pending < DEPTH_W);
  assign capture = inflight && !redirect_valid;
  assign pop     = instr_valid && cpu_ready;

  assign instr_addr  = fetch_pc;
  assign instr_valid = (count != '0);
  assign instr_out   = fifo_instr[head];
  assign instr_pc    = fifo_pc[head];
  assign occupancy   = count;

  // Fetch address generation and tracking of the one outstanding read.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= pc_align(redirect_pc);
      inflight <= 1'b0;
    end else if (issue) begin
      fetch_pc    <= pc_inc(fetch_pc);
      inflight    <= 1'b1;
      inflight_pc <= fetch_pc;
    end else begin
      inflight <= 1'b0;
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue outright.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (capture) tail <= tail + PW'(1);
      if (pop)     head <= head + PW'(1);
      unique case ({capture, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage: the returning word is written at tail tagged with its PC.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
      end
    end else if (capture) begin
      fifo_pc[tail]    <= inflight_pc;
      fifo_instr[tail] <= instruction;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Self-checking bench for instr_prefetch_buffer with a scoreboard of
// expected {pc, instruction} pairs in delivery order.
module tb_instr_prefetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] MAGIC    = 32'hA5A5_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic        CLK;
  logic        Reset;
  logic [31:0] instr_addr;
  logic [31:0] instruction;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        cpu_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [$clog2(DEPTH):0] occupancy;

  exp_t sb[$];
  int   n_checks;
  int   n_pass;
  int   n_deliv;

  instr_prefetch_buffer #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .CLK            (CLK),
    .Reset          (Reset),
    .instr_addr     (instr_addr),
    .instruction    (instruction),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .cpu_ready      (cpu_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .occupancy      (occupancy)
  );

  // Clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous-read instruction memory: word = address ^ MAGIC.
  always @(posedge CLK) instruction <= instr_addr ^ MAGIC;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic push_stream(input logic [31:0] start, input int n);
    logic [31:0] pc;
    pc = start;
    for (int k = 0; k < n; k++) begin
      sb.push_back({pc, pc ^ MAGIC});
      pc = pc + 32'd4;
    end
  endtask

  // One clock cycle: score any delivery at mid-cycle, re-seed expectations
  // on a redirect, then move to just after the next rising edge.
  task automatic step();
    exp_t e;
    @(negedge CLK);
    if (instr_valid && cpu_ready) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("deliv_pc", instr_pc, e.pc);
        check("deliv_instr", instr_out, e.ins);
      end
      n_deliv++;
    end
    if (redirect_valid) begin
      sb.delete();
      push_stream(redirect_pc & 32'hFFFF_FFFC, 40);
    end
    @(posedge CLK);
    #1;
  endtask

  // Reset for two cycles, release just after an edge: caller is in cycle 0.
  task automatic do_reset();
    Reset          = 1'b1;
    cpu_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    step();
    step();
    Reset = 1'b0;
    sb.delete();
    push_stream(RESET_PC, 60);
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_deliv  = 0;
    Reset    = 1'b1;
    cpu_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    #1;
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_addr", instr_addr, RESET_PC);
    check("rst_occ", 32'(occupancy), 32'd0);

    // Streaming with cpu_ready high from reset release.
    do_reset();
    cpu_ready = 1'b1;
    check("c0_valid", 32'(instr_valid), 32'd0);
    check("c0_addr", instr_addr, RESET_PC);
    step();
    check("c1_valid", 32'(instr_valid), 32'd0);
    step();
    check("c2_valid", 32'(instr_valid), 32'd1);
    check("c2_pc", instr_pc, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check("stream_valid", 32'(instr_valid), 32'd1);
      check("stream_pc", instr_pc, 32'(i * 4));
    end

    // Redirect coinciding with a pop, then stream resumes at the target.
    do_redirect(32'h0000_0200);
    check("rp_occ", 32'(occupancy), 32'd0);
    check("rp_addr", instr_addr, 32'h0000_0200);
    check("rp_valid1", 32'(instr_valid), 32'd0);
    step();
    check("rp_valid2", 32'(instr_valid), 32'd0);
    step();
    check("rp_valid3", 32'(instr_valid), 32'd1);
    check("rp_pc", instr_pc, 32'h0000_0200);
    for (int i = 0; i < 4; i++) step();

    // Redirect held three cycles with changing targets.
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0300; step();
    redirect_pc = 32'h0000_0340; step();
    check("hold_occ", 32'(occupancy), 32'd0);
    redirect_pc = 32'h0000_0383; step();
    redirect_valid = 1'b0;
    check("hold_addr", instr_addr, 32'h0000_0380);
    check("hold_valid1", 32'(instr_valid), 32'd0);
    step();
    check("hold_valid2", 32'(instr_valid), 32'd0);
    step();
    check("hold_valid3", 32'(instr_valid), 32'd1);
    check("hold_pc", instr_pc, 32'h0000_0380);
    for (int i = 0; i < 4; i++) step();

    // Wrap through the top of the address space.
    do_redirect(32'hFFFF_FFF8);
    step();
    step();
    check("wrap_pc0", instr_pc, 32'hFFFF_FFF8);
    step();
    check("wrap_pc1", instr_pc, 32'hFFFF_FFFC);
    step();
    check("wrap_pc2", instr_pc, 32'h0000_0000);
    step();
    check("wrap_pc3", instr_pc, 32'h0000_0004);
    step();

    // Fill with the CPU stalled, then drain.
    do_reset();
    for (int i = 0; i < 8; i++) step();
    check("full_occ", 32'(occupancy), 32'(DEPTH));
    check("full_addr", instr_addr, 32'd16);
    step();
    check("full_occ_hold", 32'(occupancy), 32'(DEPTH));
    check("full_head", instr_pc, 32'h0);
    cpu_ready = 1'b1;
    n_deliv = 0;
    for (int i = 0; i < 6; i++) begin
      check("drain_valid", 32'(instr_valid), 32'd1);
      step();
    end
    check("drain_cnt", 32'(n_deliv), 32'd6);

    // Redirect with three entries queued and one read in flight.
    do_reset();
    for (int i = 0; i < 4; i++) step();
    check("rd_occ_before", 32'(occupancy), 32'd3);
    do_redirect(32'h0000_0103);
    cpu_ready = 1'b1;
    check("rd_occ", 32'(occupancy), 32'd0);
    check("rd_addr", instr_addr, 32'h0000_0100);
    check("rd_valid1", 32'(instr_valid), 32'd0);
    step();
    check("rd_valid2", 32'(instr_valid), 32'd0);
    step();
    check("rd_valid3", 32'(instr_valid), 32'd1);
    check("rd_pc", instr_pc, 32'h0000_0100);
    for (int i = 0; i < 5; i++) step();

    // Asynchronous reset between edges while full.
    do_reset();
    for (int i = 0; i < 7; i++) step();
    check("ar_full", 32'(occupancy), 32'(DEPTH));
    #2;
    Reset = 1'b1;
    #1;
    check("ar_valid", 32'(instr_valid), 32'd0);
    check("ar_occ", 32'(occupancy), 32'd0);
    check("ar_addr", instr_addr, RESET_PC);
    check("ar_out", instr_out, 32'h0);
    check("ar_pc", instr_pc, 32'h0);
    @(posedge CLK);
    #1;
    do_reset();
    cpu_ready = 1'b1;
    check("ar_c0_addr", instr_addr, RESET_PC);
    step();
    check("ar_c1_valid", 32'(instr_valid), 32'd0);
    step();
    check("ar_c2_valid", 32'(instr_valid), 32'd1);
    check("ar_c2_pc", instr_pc, RESET_PC);
    for (int i = 0; i < 5; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
